// File: rtl/defs_pkg.sv
// Shared types and widths for the D1->E issue controller.
package defs_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    TRAP  = 2'd3
  } issue_state_e;

  // Wide enough to hold a load count of 0..4.
  localparam int MaxLoadsW = 3;
  localparam int FlushCntW = 2;

endpackage

// File: rtl/issue_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per register plus a count of loads in flight.
module issue_scoreboard
  import defs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [4:0]           set_rd,
  input  logic                 clr_en,
  input  logic [4:0]           clr_rd,
  input  logic                 inc_en,
  output logic [31:0]          pending_o,
  output logic [MaxLoadsW-1:0] load_cnt_o
);

  logic [31:0]          pending_q, pending_d;
  logic [MaxLoadsW-1:0] load_cnt_q, load_cnt_d;

  // The set is applied after the clear so a same-register set/clear leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_rd] = 1'b0;
    if (set_en) pending_d[set_rd] = 1'b1;
    pending_d[0] = 1'b0;

    load_cnt_d = load_cnt_q;
    case ({inc_en, clr_en})
      2'b10: load_cnt_d = load_cnt_q + MaxLoadsW'(1);
      2'b01: if (load_cnt_q != '0) load_cnt_d = load_cnt_q - MaxLoadsW'(1);
      default: load_cnt_d = load_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      load_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  assign pending_o  = pending_q;
  assign load_cnt_o = load_cnt_q;

endmodule

// File: rtl/issue_ctl.sv
// D1->E issue sequencer: hazard detection, stall/bubble generation and redirect/trap flushing.
module issue_ctl
  import defs_pkg::*;
#(
  parameter int MaxLoads    = 2,
  parameter int FlushCycles = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_d1,
  input  logic [4:0]  rs1_addr_d1,
  input  logic [4:0]  rs2_addr_d1,
  input  logic        rs1_en_d1,
  input  logic        rs2_en_d1,
  input  logic [4:0]  rd_addr_d1,
  input  logic        rd_en_d1,
  input  logic        load_d1,
  input  logic        valid_e,
  input  logic        br_mispredict_e,
  input  logic        illegal_e,
  input  logic        lsu_resp_valid,
  input  logic [4:0]  lsu_resp_rd,
  output logic        stall_d1,
  output logic        bubble_e,
  output logic        flush_d1,
  output logic        trap_req,
  output logic [31:0] pending_o,
  output logic [1:0]  state_o
);

  localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(FlushCycles - 1);
  localparam logic [MaxLoadsW-1:0] LoadLimit = MaxLoadsW'(MaxLoads);

  issue_state_e          state_q, state_d;
  logic [FlushCntW-1:0]  flush_cnt_q, flush_cnt_d;
  logic                  trap_req_q, trap_req_d;

  logic [31:0]           pending;
  logic [MaxLoadsW-1:0]  load_cnt;
  logic                  hz, issue, redirect, trap_ev;
  logic                  sb_set_en, sb_inc_en;

  assign redirect = valid_e & br_mispredict_e;
  assign trap_ev  = valid_e & illegal_e;

  assign hz = valid_d1 & ((rs1_en_d1 & pending[rs1_addr_d1]) |
                          (rs2_en_d1 & pending[rs2_addr_d1]) |
                          (rd_en_d1  & pending[rd_addr_d1])  |
                          (load_d1   & (load_cnt == LoadLimit)));

  // A stalled instruction issues in the very cycle its hazard drops, so STALL issues too.
  assign issue = valid_d1 & ((state_q == RUN) | (state_q == STALL)) &
                 ~hz & ~br_mispredict_e & ~illegal_e;

  assign sb_inc_en = issue & load_d1;
  assign sb_set_en = sb_inc_en & rd_en_d1 & (rd_addr_d1 != 5'd0);

  issue_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (sb_set_en),
    .set_rd     (rd_addr_d1),
    .clr_en     (lsu_resp_valid),
    .clr_rd     (lsu_resp_rd),
    .inc_en     (sb_inc_en),
    .pending_o  (pending),
    .load_cnt_o (load_cnt)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_d1    = 1'b0;
    bubble_e    = 1'b0;
    flush_d1    = 1'b0;

    case (state_q)
      RUN, STALL: begin
        stall_d1 = hz & ~trap_ev & ~redirect;
        bubble_e = hz | trap_ev | redirect;
        if (trap_ev) begin
          state_d = TRAP;
        end else if (redirect) begin
          state_d     = FLUSH;
          flush_cnt_d = FlushLast;
        end else if (hz) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
      // E is bubbled here, so only a branch redirect can still be seen; it restarts the count.
      FLUSH: begin
        flush_d1 = 1'b1;
        bubble_e = 1'b1;
        if (redirect) begin
          flush_cnt_d = FlushLast;
        end else if (flush_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FlushCntW'(1);
        end
      end
      TRAP: begin
        bubble_e    = 1'b1;
        state_d     = FLUSH;
        flush_cnt_d = FlushLast;
      end
      default: state_d = RUN;
    endcase

    trap_req_d = (state_d == TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      trap_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      trap_req_q  <= trap_req_d;
    end
  end

  assign trap_req  = trap_req_q;
  assign pending_o = pending;
  assign state_o   = state_q;

endmodule

// File: tb/tb_issue_ctl.sv
// Directed self-checking bench for issue_ctl (MaxLoads=2, FlushCycles=2).
module tb_issue_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d1;
  logic [4:0]  rs1_addr_d1, rs2_addr_d1, rd_addr_d1;
  logic        rs1_en_d1, rs2_en_d1, rd_en_d1, load_d1;
  logic        valid_e, br_mispredict_e, illegal_e;
  logic        lsu_resp_valid;
  logic [4:0]  lsu_resp_rd;
  logic        stall_d1, bubble_e, flush_d1, trap_req;
  logic [31:0] pending_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_ctl #(.MaxLoads(2), .FlushCycles(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_d1        (valid_d1),
    .rs1_addr_d1     (rs1_addr_d1),
    .rs2_addr_d1     (rs2_addr_d1),
    .rs1_en_d1       (rs1_en_d1),
    .rs2_en_d1       (rs2_en_d1),
    .rd_addr_d1      (rd_addr_d1),
    .rd_en_d1        (rd_en_d1),
    .load_d1         (load_d1),
    .valid_e         (valid_e),
    .br_mispredict_e (br_mispredict_e),
    .illegal_e       (illegal_e),
    .lsu_resp_valid  (lsu_resp_valid),
    .lsu_resp_rd     (lsu_resp_rd),
    .stall_d1        (stall_d1),
    .bubble_e        (bubble_e),
    .flush_d1        (flush_d1),
    .trap_req        (trap_req),
    .pending_o       (pending_o),
    .state_o         (state_o)
  );

  task automatic clear_inputs();
    valid_d1 = 0; rs1_addr_d1 = 0; rs2_addr_d1 = 0; rd_addr_d1 = 0;
    rs1_en_d1 = 0; rs2_en_d1 = 0; rd_en_d1 = 0; load_d1 = 0;
    valid_e = 0; br_mispredict_e = 0; illegal_e = 0;
    lsu_resp_valid = 0; lsu_resp_rd = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
    n_checks++; if (pending_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pending: got %h want 0", pending_o); end
    n_checks++; if ({stall_d1, bubble_e, flush_d1, trap_req} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %b want 0000", {stall_d1, bubble_e, flush_d1, trap_req}); end
    n_checks++; if (dut.u_sb.load_cnt_q !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", dut.u_sb.load_cnt_q); end
  endtask

  task automatic test_load_use();
    next_cycle(); clear_inputs();
    valid_d1 = 1; load_d1 = 1; rd_en_d1 = 1; rd_addr_d1 = 5; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_load_stall: got %b want 0", stall_d1); end
    next_cycle(); load_d1 = 0; rd_en_d1 = 0; rs1_en_d1 = 1; rs1_addr_d1 = 5; #1;
    n_checks++; if (pending_o !== 32'h0000_0020) begin n_fail++; $display("[TB] FAIL lu_pending: got %h want 00000020", pending_o); end
    n_checks++; if ({stall_d1, bubble_e} !== 2'b11) begin n_fail++; $display("[TB] FAIL lu_stall_run: got %b want 11", {stall_d1, bubble_e}); end
    next_cycle(); lsu_resp_valid = 1; lsu_resp_rd = 5; #1;
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("[TB] FAIL lu_state_stall: got %0d want 1", state_o); end
    n_checks++; if ({stall_d1, bubble_e} !== 2'b11) begin n_fail++; $display("[TB] FAIL lu_stall_resp: got %b want 11", {stall_d1, bubble_e}); end
    next_cycle(); lsu_resp_valid = 0; #1;
    n_checks++; if (pending_o !== 32'h0) begin n_fail++; $display("[TB] FAIL lu_cleared: got %h want 0", pending_o); end
    n_checks++; if ({stall_d1, bubble_e} !== 2'b00) begin n_fail++; $display("[TB] FAIL lu_issue: got %b want 00", {stall_d1, bubble_e}); end
    next_cycle(); clear_inputs(); #1;
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("[TB] FAIL lu_back_run: got %0d want 0", state_o); end
  endtask

  task automatic test_x0_load();
    next_cycle(); clear_inputs();
    valid_d1 = 1; load_d1 = 1; rd_en_d1 = 1; rd_addr_d1 = 0; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_load_stall: got %b want 0", stall_d1); end
    next_cycle(); load_d1 = 0; rs1_en_d1 = 1; rs2_en_d1 = 1; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_read_stall: got %b want 0", stall_d1); end
    n_checks++; if (pending_o !== 32'h0) begin n_fail++; $display("[TB] FAIL x0_pending: got %h want 0", pending_o); end
    n_checks++; if (dut.u_sb.load_cnt_q !== 3'd1) begin n_fail++; $display("[TB] FAIL x0_cnt: got %0d want 1", dut.u_sb.load_cnt_q); end
    next_cycle(); clear_inputs(); lsu_resp_valid = 1; lsu_resp_rd = 0;
    next_cycle(); clear_inputs(); #1;
    n_checks++; if (dut.u_sb.load_cnt_q !== 3'd0) begin n_fail++; $display("[TB] FAIL x0_cnt_ret: got %0d want 0", dut.u_sb.load_cnt_q); end
  endtask

  task automatic test_max_loads();
    next_cycle(); clear_inputs();
    valid_d1 = 1; load_d1 = 1; rd_en_d1 = 1; rd_addr_d1 = 3; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL ml_first: got %b want 0", stall_d1); end
    next_cycle(); rd_addr_d1 = 4; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL ml_second: got %b want 0", stall_d1); end
    next_cycle(); rd_addr_d1 = 6; #1;
    n_checks++; if (pending_o !== 32'h0000_0018) begin n_fail++; $display("[TB] FAIL ml_pending2: got %h want 00000018", pending_o); end
    n_checks++; if (stall_d1 !== 1'b1) begin n_fail++; $display("[TB] FAIL ml_full_stall: got %b want 1", stall_d1); end
    next_cycle(); lsu_resp_valid = 1; lsu_resp_rd = 3; #1;
    n_checks++; if ({state_o, stall_d1} !== 3'b011) begin n_fail++; $display("[TB] FAIL ml_stall_state: got %b want 011", {state_o, stall_d1}); end
    next_cycle(); lsu_resp_valid = 0; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL ml_issue: got %b want 0", stall_d1); end
    next_cycle(); clear_inputs(); #1;
    n_checks++; if (pending_o !== 32'h0000_0050) begin n_fail++; $display("[TB] FAIL ml_pending_after: got %h want 00000050", pending_o); end
    n_checks++; if (dut.u_sb.load_cnt_q !== 3'd2) begin n_fail++; $display("[TB] FAIL ml_cnt: got %0d want 2", dut.u_sb.load_cnt_q); end
    lsu_resp_valid = 1; lsu_resp_rd = 4;
    next_cycle(); lsu_resp_rd = 6;
    next_cycle(); clear_inputs(); #1;
    n_checks++; if ({pending_o, dut.u_sb.load_cnt_q} !== 35'h0) begin n_fail++; $display("[TB] FAIL ml_drain: got %h/%0d want 0/0", pending_o, dut.u_sb.load_cnt_q); end
  endtask

  task automatic test_hazard_ports();
    next_cycle(); clear_inputs();
    valid_d1 = 1; load_d1 = 1; rd_en_d1 = 1; rd_addr_d1 = 11;
    next_cycle(); load_d1 = 0; rd_en_d1 = 0; rs2_en_d1 = 1; rs2_addr_d1 = 11; #1;
    n_checks++; if (stall_d1 !== 1'b1) begin n_fail++; $display("[TB] FAIL hz_rs2: got %b want 1", stall_d1); end
    next_cycle(); rs2_en_d1 = 0; rd_en_d1 = 1; rd_addr_d1 = 11; #1;
    n_checks++; if (stall_d1 !== 1'b1) begin n_fail++; $display("[TB] FAIL hz_waw: got %b want 1", stall_d1); end
    next_cycle(); rd_en_d1 = 0; rs1_addr_d1 = 11; rs1_en_d1 = 0; #1;
    n_checks++; if ({stall_d1, bubble_e} !== 2'b00) begin n_fail++; $display("[TB] FAIL hz_rs1_disabled: got %b want 00", {stall_d1, bubble_e}); end
    next_cycle(); clear_inputs(); rs1_en_d1 = 1; rs1_addr_d1 = 11; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL hz_no_valid: got %b want 0", stall_d1); end
    lsu_resp_valid = 1; lsu_resp_rd = 11;
    next_cycle(); clear_inputs();
  endtask

  task automatic test_mispredict();
    next_cycle(); clear_inputs();
    valid_d1 = 1; load_d1 = 1; rd_en_d1 = 1; rd_addr_d1 = 9;
    next_cycle(); load_d1 = 0; rd_en_d1 = 0; rs1_en_d1 = 1; rs1_addr_d1 = 9;
    valid_e = 1; br_mispredict_e = 1; #1;
    n_checks++; if ({stall_d1, bubble_e, flush_d1} !== 3'b010) begin n_fail++; $display("[TB] FAIL bm_redirect_cycle: got %b want 010", {stall_d1, bubble_e, flush_d1}); end
    next_cycle(); clear_inputs(); #1;
    n_checks++; if ({state_o, flush_d1, bubble_e} !== 4'b1011) begin n_fail++; $display("[TB] FAIL bm_flush1: got %b want 1011", {state_o, flush_d1, bubble_e}); end
    next_cycle(); #1;
    n_checks++; if (flush_d1 !== 1'b1) begin n_fail++; $display("[TB] FAIL bm_flush2: got %b want 1", flush_d1); end
    next_cycle(); #1;
    n_checks++; if ({state_o, flush_d1} !== 3'b000) begin n_fail++; $display("[TB] FAIL bm_flush_end: got %b want 000", {state_o, flush_d1}); end
    n_checks++; if (pending_o !== 32'h0000_0200) begin n_fail++; $display("[TB] FAIL bm_retained: got %h want 00000200", pending_o); end
    lsu_resp_valid = 1; lsu_resp_rd = 9;
    next_cycle(); clear_inputs();
  endtask

  task automatic test_trap();
    next_cycle(); clear_inputs();
    valid_d1 = 1; rs1_en_d1 = 1; rs1_addr_d1 = 1;
    valid_e = 1; illegal_e = 1; br_mispredict_e = 1; #1;
    n_checks++; if ({stall_d1, bubble_e, flush_d1, trap_req} !== 4'b0100) begin n_fail++; $display("[TB] FAIL tr_event_cycle: got %b want 0100", {stall_d1, bubble_e, flush_d1, trap_req}); end
    next_cycle(); clear_inputs(); #1;
    n_checks++; if ({state_o, trap_req, flush_d1} !== 4'b1110) begin n_fail++; $display("[TB] FAIL tr_trap: got %b want 1110", {state_o, trap_req, flush_d1}); end
    next_cycle(); #1;
    n_checks++; if ({state_o, trap_req, flush_d1} !== 4'b1001) begin n_fail++; $display("[TB] FAIL tr_flush1: got %b want 1001", {state_o, trap_req, flush_d1}); end
    next_cycle(); #1;
    n_checks++; if ({state_o, trap_req, flush_d1} !== 4'b1001) begin n_fail++; $display("[TB] FAIL tr_flush2: got %b want 1001", {state_o, trap_req, flush_d1}); end
    next_cycle(); #1;
    n_checks++; if ({state_o, trap_req, flush_d1} !== 4'b0000) begin n_fail++; $display("[TB] FAIL tr_done: got %b want 0000", {state_o, trap_req, flush_d1}); end
  endtask

  task automatic test_flush_restart();
    next_cycle(); clear_inputs();
    valid_e = 1; br_mispredict_e = 1;
    next_cycle(); #1;
    n_checks++; if ({state_o, flush_d1} !== 3'b101) begin n_fail++; $display("[TB] FAIL fr_first: got %b want 101", {state_o, flush_d1}); end
    next_cycle(); br_mispredict_e = 0; illegal_e = 1; #1;
    n_checks++; if ({state_o, flush_d1} !== 3'b101) begin n_fail++; $display("[TB] FAIL fr_restart: got %b want 101", {state_o, flush_d1}); end
    next_cycle(); clear_inputs(); #1;
    n_checks++; if ({state_o, trap_req, flush_d1} !== 4'b1001) begin n_fail++; $display("[TB] FAIL fr_extended: got %b want 1001", {state_o, trap_req, flush_d1}); end
    next_cycle(); #1;
    n_checks++; if ({state_o, flush_d1} !== 3'b000) begin n_fail++; $display("[TB] FAIL fr_done: got %b want 000", {state_o, flush_d1}); end
  endtask

  task automatic test_back_to_back();
    next_cycle(); clear_inputs();
    valid_d1 = 1; load_d1 = 1; rd_en_d1 = 1; rd_addr_d1 = 0;
    next_cycle(); rd_addr_d1 = 7; lsu_resp_valid = 1; lsu_resp_rd = 7; #1;
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("[TB] FAIL bb_issue: got %b want 0", stall_d1); end
    next_cycle(); clear_inputs(); valid_d1 = 1; rs1_en_d1 = 1; rs1_addr_d1 = 7; #1;
    n_checks++; if (pending_o !== 32'h0000_0080) begin n_fail++; $display("[TB] FAIL bb_set_wins: got %h want 00000080", pending_o); end
    n_checks++; if (dut.u_sb.load_cnt_q !== 3'd1) begin n_fail++; $display("[TB] FAIL bb_cnt: got %0d want 1", dut.u_sb.load_cnt_q); end
    n_checks++; if (stall_d1 !== 1'b1) begin n_fail++; $display("[TB] FAIL bb_stall: got %b want 1", stall_d1); end
    next_cycle(); rst = 1; #1;
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("[TB] FAIL bb_in_stall: got %0d want 1", state_o); end
    next_cycle(); rst = 0; #1;
    n_checks++; if ({stall_d1, bubble_e, flush_d1, trap_req, state_o} !== 6'b0) begin n_fail++; $display("[TB] FAIL bb_rst_outputs: got %b want 000000", {stall_d1, bubble_e, flush_d1, trap_req, state_o}); end
    n_checks++; if ({pending_o, dut.u_sb.load_cnt_q} !== 35'h0) begin n_fail++; $display("[TB] FAIL bb_rst_sb: got %h/%0d want 0/0", pending_o, dut.u_sb.load_cnt_q); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_load();
    test_max_loads();
    test_hazard_ports();
    test_mispredict();
    test_trap();
    test_flush_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
